ad9226_input: RTL
=================

// Module: ad9226_input
// PURPOSE
//  Receive-side counterpart of the AD9767 DAC output stage: captures 12-bit offset-binary samples from the AD9226 ADC.
//  Converts each sample to signed two's complement in the same 14-bit format the DAC path consumes.
//  Removes a block-averaged DC offset, flags clipping, decimates, and presents data_recv/data_valid to the 2FSK demodulator.
// PARAMETERS
//  ADC_WIDTH  12  ADC code width (offset binary)
//  OUT_WIDTH  14  output width (signed); sample left-aligned, shift = OUT_WIDTH-ADC_WIDTH
//  AVG_LOG2   10  DC-estimate window = 2^AVG_LOG2 enabled samples
//  DECIM      1   output decimation factor (>=1)
// PORTS
//  clk_sample  in   1          sampling clock
//  rst_n       in   1          asynchronous reset, active low
//  ad_data     in   ADC_WIDTH  ADC output code, offset binary
//  ad_otr      in   1          ADC out-of-range pin
//  en          in   1          capture enable
//  clip_clr    in   1          synchronous clear of clip_count
//  ad_clk      out  1          clock to AD9226, = clk_sample (combinational)
//  data_recv   out  OUT_WIDTH  signed, DC-corrected sample
//  data_valid  out  1          data_recv qualifier, one cycle per output sample
//  dc_offset   out  OUT_WIDTH  signed current DC estimate
//  clip_flag   out  1          aligned with data_recv: otr or saturation on this sample
//  clip_count  out  16         clipped-sample counter, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all registers, data_recv, data_valid, dc_offset, clip_flag, clip_count, and internal counters/accumulator = 0.
//  ad_clk is not reset.
//  Pipeline: S1 registers ad_data, ad_otr, en at edge N.
//  S2 at N+1: x = {~d[MSB], d[MSB-1:0]} << (OUT_WIDTH-ADC_WIDTH), signed.
//  OUT at N+2: data_recv = sat(x - dc_offset). Latency is 3 edges from input setup to output; the pipeline runs every cycle.
//  Saturation: the difference is computed in OUT_WIDTH+1 bits and clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//  clip_flag = S2 otr | clamp occurred.
//  clip_count += 1 on each clip_flag cycle, holding at 16'hFFFF. clip_clr has priority: if clip_clr and clip_flag occur together, the result is 0.
//  Decimation: the counter dcnt (0..DECIM-1) advances on each S2 cycle with en=1 and wraps at DECIM-1.
//  data_valid is asserted for samples where en=1 and dcnt==0. DECIM=1 gives continuous valid while en=1.
//  DC estimator:
//   - Signed accumulator of width OUT_WIDTH+AVG_LOG2 sums x for enabled S2 samples; the window counter counts 0..2^AVG_LOG2-1.
//   - On the last sample of a window: dc_offset <= (acc + x) >>> AVG_LOG2 (arithmetic, floor), then acc <= 0 and the counter <= 0.
//   - The new dc_offset applies to samples from the next edge onward. dc_offset = 0 until the first window completes.
//  en low: data_valid=0; dcnt, window counter and accumulator clear to 0; dc_offset and clip_count hold.
//   Re-enabling starts a fresh window.
//  rst_n asserted mid-window: everything clears immediately; the estimate restarts from 0.
// TESTING
//  1. ad_data=12'h800, ad_otr=0, en=1, DECIM=1 -> data_recv=0 from edge 3; data_valid=1 every cycle; clip_flag=0.
//  2. Before first window: ad_data=12'hFFF -> data_recv=14'h1FFC (8188); 12'h000 -> 14'h2000 (-8192); 12'h801 -> 14'h0004.
//  3. AVG_LOG2=4: 16 samples of 12'h810 (x=+64) -> dc_offset=14'h0040 after 16th; following 12'h810 gives data_recv=0.
//  4. With dc_offset=+64, ad_data=12'h000 -> data_recv clamps to 14'h2000, clip_flag=1, clip_count+1.
//     ad_otr=1 with 12'h800 -> clip_flag=1. clip_clr pulse -> clip_count=0.
//  5. DECIM=4, en=1 -> data_valid high 1 of every 4 cycles. en low for 2 cycles -> no valid; the next enabled sample is valid.
//  6. rst_n low during sample 8 of a 16-sample window -> all outputs 0 at once. After release, dc_offset stays 0 until 16 new samples.

Source files
------------

// File: rtl/ad9226_input.sv
// AD9226 ADC capture stage. Converts offset-binary ADC codes to left-aligned
// signed samples and subtracts a block-averaged DC estimate. It flags and
// counts clipping, and decimates the stream for the 2FSK demodulator.
module ad9226_input #(
  parameter int ADC_WIDTH = 12,
  parameter int OUT_WIDTH = 14,
  parameter int AVG_LOG2  = 10,
  parameter int DECIM     = 1
) (
  input  logic                 clk_sample,
  input  logic                 rst_n,
  input  logic [ADC_WIDTH-1:0] ad_data,
  input  logic                 ad_otr,
  input  logic                 en,
  input  logic                 clip_clr,
  output logic                 ad_clk,
  output logic [OUT_WIDTH-1:0] data_recv,
  output logic                 data_valid,
  output logic [OUT_WIDTH-1:0] dc_offset,
  output logic                 clip_flag,
  output logic [15:0]          clip_count
);

  localparam int SHIFT  = OUT_WIDTH - ADC_WIDTH;
  localparam int ACC_W  = OUT_WIDTH + AVG_LOG2;
  localparam int DCNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  // S1: raw ADC capture
  logic [ADC_WIDTH-1:0] d1;
  logic                 otr1;
  logic                 en1;

  // S2: signed, left-aligned sample
  logic [OUT_WIDTH-1:0] x2;
  logic                 otr2;
  logic                 en2;

  logic [OUT_WIDTH-1:0] x_next;
  logic [OUT_WIDTH:0]   diff;
  logic                 ovf;
  logic [OUT_WIDTH-1:0] sat;
  logic                 clip_next;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [AVG_LOG2-1:0]  win_cnt;
  logic [DCNT_W-1:0]    dcnt;

  assign ad_clk = clk_sample;

  // Offset binary to two's complement: invert MSB, then left-align.
  always_comb begin
    x_next = OUT_WIDTH'({~d1[ADC_WIDTH-1], d1[ADC_WIDTH-2:0]}) << SHIFT;
  end

  // Subtract the DC estimate one bit wider, then clamp to the output range.
  always_comb begin
    diff      = {x2[OUT_WIDTH-1], x2} - {dc_offset[OUT_WIDTH-1], dc_offset};
    ovf       = diff[OUT_WIDTH] ^ diff[OUT_WIDTH-1];
    sat       = ovf ? {diff[OUT_WIDTH], {(OUT_WIDTH-1){~diff[OUT_WIDTH]}}}
                    : diff[OUT_WIDTH-1:0];
    clip_next = otr2 | ovf;
    acc_sum   = acc + {{AVG_LOG2{x2[OUT_WIDTH-1]}}, x2};
  end

  // Input and conversion pipeline stages, running every cycle.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      d1   <= '0;
      otr1 <= 1'b0;
      en1  <= 1'b0;
      x2   <= '0;
      otr2 <= 1'b0;
      en2  <= 1'b0;
    end else begin
      d1   <= ad_data;
      otr1 <= ad_otr;
      en1  <= en;
      x2   <= x_next;
      otr2 <= otr1;
      en2  <= en1;
    end
  end

  // Output stage: corrected sample, clip tracking, decimation and DC estimate.
  always_ff @(posedge clk_sample or negedge rst_n) begin
    if (!rst_n) begin
      data_recv  <= '0;
      data_valid <= 1'b0;
      clip_flag  <= 1'b0;
      clip_count <= '0;
      dc_offset  <= '0;
      acc        <= '0;
      win_cnt    <= '0;
      dcnt       <= '0;
    end else begin
      data_recv  <= sat;
      clip_flag  <= clip_next;
      data_valid <= en2 && (dcnt == '0);

      if (clip_clr) begin
        clip_count <= '0;
      end else if (en2 && clip_next && (clip_count != '1)) begin
        clip_count <= clip_count + 16'd1;
      end

      if (en2) begin
        dcnt <= (dcnt == DCNT_W'(DECIM - 1)) ? '0 : dcnt + 1'b1;
        // Window closes on this sample: the upper slice of acc+x is the
        // floor-divided mean, and takes effect from the next edge.
        if (win_cnt == '1) begin
          dc_offset <= acc_sum[ACC_W-1:AVG_LOG2];
          acc       <= '0;
          win_cnt   <= '0;
        end else begin
          acc     <= acc_sum;
          win_cnt <= win_cnt + 1'b1;
        end
      end else begin
        dcnt    <= '0;
        acc     <= '0;
        win_cnt <= '0;
      end
    end
  end

endmodule
